bypass_nf_front_multi: RTL and testbench

Parametrised successor to the two-way bypass front end: steers each packet and its metadata descriptor to one of `NUM_LANES` NF lanes or to a bypass path. Lane choice is either round-robin over non-congested lanes or flow-affine by hash field, selected by `MODE`. It sits after the parser/metadata stage and in front of the replicated NF engines. Per-destination packet counters are provided for debug.

---
 rtl/bypass_nf_front_multi.sv | 178 +++++++++++++++++
 tb/tb_bypass_nf_front_multi.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_nf_front_multi.sv
// rtl/bypass_nf_front_multi.sv - steers packet+descriptor pairs to one of NUM_LANES NF lanes or a bypass path
// Decision in IDLE (round-robin or hash lane), then beats pass through combinationally in FWD.
module bypass_nf_front_multi #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_W     = 512,
  parameter int EMPTY_W    = 6,
  parameter int META_W     = 512,
  parameter int MODE       = 0,
  parameter int BYPASS_BIT = 0,
  parameter int HASH_LSB   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_pkt_data,
  input  logic                      in_pkt_sop,
  input  logic                      in_pkt_eop,
  input  logic [EMPTY_W-1:0]        in_pkt_empty,
  input  logic                      in_pkt_valid,
  output logic                      in_pkt_ready,
  input  logic [META_W-1:0]         in_meta_data,
  input  logic                      in_meta_valid,
  output logic                      in_meta_ready,
  output logic [DATA_W-1:0]         out_pkt_data,
  output logic                      out_pkt_sop,
  output logic                      out_pkt_eop,
  output logic [EMPTY_W-1:0]        out_pkt_empty,
  output logic [NUM_LANES-1:0]      out_pkt_valid,
  input  logic [NUM_LANES-1:0]      out_pkt_ready,
  input  logic [NUM_LANES-1:0]      out_pkt_almost_full,
  output logic [META_W-1:0]         out_meta_data,
  output logic [NUM_LANES-1:0]      out_meta_valid,
  input  logic [NUM_LANES-1:0]      out_meta_ready,
  input  logic [NUM_LANES-1:0]      out_meta_almost_full,
  output logic [DATA_W-1:0]         bypass_pkt_data,
  output logic                      bypass_pkt_sop,
  output logic                      bypass_pkt_eop,
  output logic [EMPTY_W-1:0]        bypass_pkt_empty,
  output logic                      bypass_pkt_valid,
  input  logic                      bypass_pkt_ready,
  input  logic                      bypass_pkt_almost_full,
  output logic [META_W-1:0]         bypass_meta_data,
  output logic                      bypass_meta_valid,
  input  logic                      bypass_meta_ready,
  input  logic                      bypass_meta_almost_full,
  output logic [NUM_LANES*32-1:0]   stat_pkt_cnt,
  output logic [31:0]               stat_bypass_cnt
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {IDLE, FWD} state_t;

  state_t                   r_state, w_state_nxt;
  logic [LANE_W-1:0]        r_rr_ptr, r_dest;
  logic                     r_byp, r_meta_valid;
  logic [META_W-1:0]        r_meta_data;
  logic [NUM_LANES*32-1:0]  r_stat_pkt_cnt;
  logic [31:0]              r_stat_bypass_cnt;

  logic [NUM_LANES-1:0]     w_elig;
  logic [LANE_W-1:0]        w_h, w_hash_lane, w_rr_grant, w_rr_nxt, w_lane;
  logic                     w_byp_req, w_rr_found, w_dest_ok;
  logic                     w_meta_rdy, w_meta_free, w_pkt_rdy, w_fire, w_eop_hs;
  int                       w_idx;

  assign w_elig    = ~(out_pkt_almost_full | out_meta_almost_full);
  assign w_byp_req = in_meta_data[BYPASS_BIT];
  assign w_h       = in_meta_data[HASH_LSB +: LANE_W];

  // Hash field is at most one lane-count too large, so a single subtract folds it.
  assign w_hash_lane = ({1'b0, w_h} >= (LANE_W+1)'(NUM_LANES)) ? w_h - LANE_W'(NUM_LANES) : w_h;

  always_comb begin
    w_rr_found = 1'b0;
    w_rr_grant = '0;
    w_idx      = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_LANES) w_idx = w_idx - NUM_LANES;
      if (!w_rr_found && w_elig[LANE_W'(w_idx)]) begin
        w_rr_found = 1'b1;
        w_rr_grant = LANE_W'(w_idx);
      end
    end
  end

  assign w_rr_nxt  = (w_rr_grant == LANE_W'(NUM_LANES - 1)) ? '0 : w_rr_grant + 1'b1;
  assign w_lane    = (MODE == 1) ? w_hash_lane : w_rr_grant;
  assign w_dest_ok = w_byp_req ? !(bypass_pkt_almost_full || bypass_meta_almost_full)
                               : ((MODE == 1) ? w_elig[w_hash_lane] : w_rr_found);

  assign w_meta_rdy  = r_byp ? bypass_meta_ready : out_meta_ready[r_dest];
  assign w_meta_free = !r_meta_valid || w_meta_rdy;
  assign w_pkt_rdy   = r_byp ? bypass_pkt_ready : out_pkt_ready[r_dest];
  assign w_fire      = !rst && (r_state == IDLE) && in_meta_valid && w_meta_free && w_dest_ok;
  assign w_eop_hs    = !rst && (r_state == FWD) && in_pkt_valid && w_pkt_rdy && in_pkt_eop;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    in_meta_ready    = 1'b0;
    in_pkt_ready     = 1'b0;
    out_pkt_valid    = '0;
    bypass_pkt_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
          in_meta_ready = 1'b1;
          w_state_nxt   = FWD;
        end
      end
      FWD: begin
        if (!rst) begin
          in_pkt_ready = w_pkt_rdy;
          if (r_byp) bypass_pkt_valid      = in_pkt_valid;
          else       out_pkt_valid[r_dest] = in_pkt_valid;
        end
        if (w_eop_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr          <= '0;
      r_dest            <= '0;
      r_byp             <= 1'b0;
      r_meta_valid      <= 1'b0;
      r_meta_data       <= '0;
      r_stat_pkt_cnt    <= '0;
      r_stat_bypass_cnt <= '0;
    end else begin
      // A reload in the drain cycle keeps the register full with no bubble.
      if (w_fire) begin
        r_meta_valid <= 1'b1;
        r_meta_data  <= in_meta_data;
        r_byp        <= w_byp_req;
        if (!w_byp_req) r_dest <= w_lane;
        if (!w_byp_req && MODE == 0) r_rr_ptr <= w_rr_nxt;
      end else if (r_meta_valid && w_meta_rdy) begin
        r_meta_valid <= 1'b0;
      end
      if (w_eop_hs) begin
        if (r_byp) r_stat_bypass_cnt <= r_stat_bypass_cnt + 32'd1;
        else begin
          for (int i = 0; i < NUM_LANES; i++)
            if (r_dest == LANE_W'(i))
              r_stat_pkt_cnt[32*i +: 32] <= r_stat_pkt_cnt[32*i +: 32] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    out_meta_valid = '0;
    if (r_meta_valid && !r_byp) out_meta_valid[r_dest] = 1'b1;
  end

  assign bypass_meta_valid = r_meta_valid && r_byp;
  assign out_meta_data     = r_meta_data;
  assign bypass_meta_data  = r_meta_data;
  assign out_pkt_data      = in_pkt_data;
  assign out_pkt_sop       = in_pkt_sop;
  assign out_pkt_eop       = in_pkt_eop;
  assign out_pkt_empty     = in_pkt_empty;
  assign bypass_pkt_data   = in_pkt_data;
  assign bypass_pkt_sop    = in_pkt_sop;
  assign bypass_pkt_eop    = in_pkt_eop;
  assign bypass_pkt_empty  = in_pkt_empty;
  assign stat_pkt_cnt      = r_stat_pkt_cnt;
  assign stat_bypass_cnt   = r_stat_bypass_cnt;

endmodule

// File: tb/tb_bypass_nf_front_multi.sv
// tb/tb_bypass_nf_front_multi.sv - self-checking bench for bypass_nf_front_multi
// A round-robin 4-lane instance driven through a scoreboard, plus a 3-lane hash instance.
module tb_bypass_nf_front_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Round-robin instance, 4 lanes
  logic [15:0]  in_pkt_data;
  logic         in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_ready;
  logic [1:0]   in_pkt_empty;
  logic [63:0]  in_meta_data;
  logic         in_meta_valid, in_meta_ready;
  logic [15:0]  out_pkt_data;
  logic         out_pkt_sop, out_pkt_eop;
  logic [1:0]   out_pkt_empty;
  logic [3:0]   out_pkt_valid, out_pkt_ready, out_pkt_almost_full;
  logic [63:0]  out_meta_data;
  logic [3:0]   out_meta_valid, out_meta_ready, out_meta_almost_full;
  logic [15:0]  bypass_pkt_data;
  logic         bypass_pkt_sop, bypass_pkt_eop, bypass_pkt_valid, bypass_pkt_ready, bypass_pkt_almost_full;
  logic [1:0]   bypass_pkt_empty;
  logic [63:0]  bypass_meta_data;
  logic         bypass_meta_valid, bypass_meta_ready, bypass_meta_almost_full;
  logic [127:0] stat_pkt_cnt;
  logic [31:0]  stat_bypass_cnt;

  // Hash instance, 3 lanes
  logic [15:0]  h_in_pkt_data;
  logic         h_in_pkt_sop, h_in_pkt_eop, h_in_pkt_valid, h_in_pkt_ready;
  logic [1:0]   h_in_pkt_empty;
  logic [63:0]  h_in_meta_data;
  logic         h_in_meta_valid, h_in_meta_ready;
  logic [15:0]  h_out_pkt_data;
  logic         h_out_pkt_sop, h_out_pkt_eop;
  logic [1:0]   h_out_pkt_empty;
  logic [2:0]   h_out_pkt_valid, h_out_pkt_ready, h_out_pkt_almost_full;
  logic [63:0]  h_out_meta_data;
  logic [2:0]   h_out_meta_valid, h_out_meta_ready, h_out_meta_almost_full;
  logic [15:0]  h_bypass_pkt_data;
  logic         h_bypass_pkt_sop, h_bypass_pkt_eop, h_bypass_pkt_valid;
  logic [1:0]   h_bypass_pkt_empty;
  logic [63:0]  h_bypass_meta_data;
  logic         h_bypass_meta_valid;
  logic [95:0]  h_stat_pkt_cnt;
  logic [31:0]  h_stat_bypass_cnt;

  bypass_nf_front_multi #(.NUM_LANES(4), .DATA_W(16), .EMPTY_W(2), .META_W(64),
                          .MODE(0), .BYPASS_BIT(0), .HASH_LSB(32)) dut (
    .clk(clk), .rst(rst),
    .in_pkt_data(in_pkt_data), .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
    .in_pkt_empty(in_pkt_empty), .in_pkt_valid(in_pkt_valid), .in_pkt_ready(in_pkt_ready),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .out_pkt_data(out_pkt_data), .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_pkt_almost_full(out_pkt_almost_full),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .out_meta_almost_full(out_meta_almost_full),
    .bypass_pkt_data(bypass_pkt_data), .bypass_pkt_sop(bypass_pkt_sop), .bypass_pkt_eop(bypass_pkt_eop),
    .bypass_pkt_empty(bypass_pkt_empty), .bypass_pkt_valid(bypass_pkt_valid),
    .bypass_pkt_ready(bypass_pkt_ready), .bypass_pkt_almost_full(bypass_pkt_almost_full),
    .bypass_meta_data(bypass_meta_data), .bypass_meta_valid(bypass_meta_valid),
    .bypass_meta_ready(bypass_meta_ready), .bypass_meta_almost_full(bypass_meta_almost_full),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_bypass_cnt(stat_bypass_cnt)
  );

  bypass_nf_front_multi #(.NUM_LANES(3), .DATA_W(16), .EMPTY_W(2), .META_W(64),
                          .MODE(1), .BYPASS_BIT(0), .HASH_LSB(32)) dut_h (
    .clk(clk), .rst(rst),
    .in_pkt_data(h_in_pkt_data), .in_pkt_sop(h_in_pkt_sop), .in_pkt_eop(h_in_pkt_eop),
    .in_pkt_empty(h_in_pkt_empty), .in_pkt_valid(h_in_pkt_valid), .in_pkt_ready(h_in_pkt_ready),
    .in_meta_data(h_in_meta_data), .in_meta_valid(h_in_meta_valid), .in_meta_ready(h_in_meta_ready),
    .out_pkt_data(h_out_pkt_data), .out_pkt_sop(h_out_pkt_sop), .out_pkt_eop(h_out_pkt_eop),
    .out_pkt_empty(h_out_pkt_empty), .out_pkt_valid(h_out_pkt_valid), .out_pkt_ready(h_out_pkt_ready),
    .out_pkt_almost_full(h_out_pkt_almost_full),
    .out_meta_data(h_out_meta_data), .out_meta_valid(h_out_meta_valid), .out_meta_ready(h_out_meta_ready),
    .out_meta_almost_full(h_out_meta_almost_full),
    .bypass_pkt_data(h_bypass_pkt_data), .bypass_pkt_sop(h_bypass_pkt_sop), .bypass_pkt_eop(h_bypass_pkt_eop),
    .bypass_pkt_empty(h_bypass_pkt_empty), .bypass_pkt_valid(h_bypass_pkt_valid),
    .bypass_pkt_ready(1'b1), .bypass_pkt_almost_full(1'b0),
    .bypass_meta_data(h_bypass_meta_data), .bypass_meta_valid(h_bypass_meta_valid),
    .bypass_meta_ready(1'b1), .bypass_meta_almost_full(1'b0),
    .stat_pkt_cnt(h_stat_pkt_cnt), .stat_bypass_cnt(h_stat_bypass_cnt)
  );

  typedef struct {int dest; logic [15:0] data; logic eop;} pkt_exp_t;
  typedef struct {int dest; logic [63:0] meta;} meta_exp_t;

  pkt_exp_t  pq[$];
  meta_exp_t mq[$];
  int        exp_cnt[5];
  int        errors = 0;
  int        checks = 0;

  // Output monitor: every handshake pops the oldest expectation (dest 4 = bypass)
  int          m_n, m_d;
  logic [15:0] m_data;
  logic        m_eop;
  logic [63:0] m_meta;
  pkt_exp_t    m_pe;
  meta_exp_t   m_me;

  always @(negedge clk) begin
    m_n = 0; m_d = -1; m_data = '0; m_eop = 1'b0;
    for (int i = 0; i < 4; i++)
      if (out_pkt_valid[i] && out_pkt_ready[i]) begin
        m_n++; m_d = i; m_data = out_pkt_data; m_eop = out_pkt_eop;
      end
    if (bypass_pkt_valid && bypass_pkt_ready) begin
      m_n++; m_d = 4; m_data = bypass_pkt_data; m_eop = bypass_pkt_eop;
    end
    if (m_n > 0) begin
      checks++;
      if (m_n > 1 || pq.size() == 0) begin
        errors++;
        $display("FAIL pkt_beat: got %0d handshakes (dest %0d) with %0d expected beats pending, required exactly 1 expected", m_n, m_d, pq.size());
      end else begin
        m_pe = pq.pop_front();
        if (m_pe.dest !== m_d || m_pe.data !== m_data || m_pe.eop !== m_eop) begin
          errors++;
          $display("FAIL pkt_beat: got dest=%0d data=%h eop=%b required dest=%0d data=%h eop=%b",
                   m_d, m_data, m_eop, m_pe.dest, m_pe.data, m_pe.eop);
        end
      end
    end
    m_n = 0; m_d = -1; m_meta = '0;
    for (int i = 0; i < 4; i++)
      if (out_meta_valid[i] && out_meta_ready[i]) begin
        m_n++; m_d = i; m_meta = out_meta_data;
      end
    if (bypass_meta_valid && bypass_meta_ready) begin
      m_n++; m_d = 4; m_meta = bypass_meta_data;
    end
    if (m_n > 0) begin
      checks++;
      if (m_n > 1 || mq.size() == 0) begin
        errors++;
        $display("FAIL meta_out: got %0d handshakes (dest %0d) with %0d pending, required exactly 1 expected", m_n, m_d, mq.size());
      end else begin
        m_me = mq.pop_front();
        if (m_me.dest !== m_d || m_me.meta !== m_meta) begin
          errors++;
          $display("FAIL meta_out: got dest=%0d meta=%h required dest=%0d meta=%h", m_d, m_meta, m_me.dest, m_me.meta);
        end
      end
    end
  end

  function automatic logic [63:0] lane_meta();
    return {$urandom, $urandom} & ~64'h1;
  endfunction

  // Sends one packet of nb beats expected at dest; rst_beat >= 0 asserts reset while that beat is offered.
  task automatic send(input logic [63:0] meta, input int nb, input int dest, input int rst_beat, input bit tog);
    int t;
    logic exp_rdy;
    logic [15:0] d;
    in_meta_data  = meta;
    in_meta_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_meta_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!in_meta_ready) begin
      errors++;
      $display("FAIL meta_accept: in_meta_ready=0 after %0d cycles, required 1", t);
      @(posedge clk); #1; in_meta_valid = 1'b0;
      return;
    end
    mq.push_back('{dest, meta});
    @(posedge clk); #1;
    in_meta_valid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      d = 16'($urandom);
      in_pkt_valid = 1'b1; in_pkt_data = d; in_pkt_empty = 2'(k);
      in_pkt_sop = (k == 0); in_pkt_eop = (k == nb - 1);
      if (k == rst_beat) begin
        rst = 1'b1;
        @(posedge clk); #1;
        in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0;
        return;
      end
      pq.push_back('{dest, d, k == nb - 1});
      if (k == nb - 1) exp_cnt[dest]++;
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (dest == 4 ? !(bypass_meta_valid === 1'b1 && out_meta_valid === 4'b0 && bypass_meta_data === meta)
                      : !(out_meta_valid === (4'b0001 << dest) && bypass_meta_valid === 1'b0 && out_meta_data === meta)) begin
          errors++;
          $display("FAIL meta_latency: got valid=%b byp=%b data=%h required dest=%0d data=%h",
                   out_meta_valid, bypass_meta_valid, out_meta_data, dest, meta);
        end
      end
      t = 0;
      while (1'b1) begin
        exp_rdy = (dest == 4) ? bypass_pkt_ready : out_pkt_ready[dest[1:0]];
        checks++;
        if (in_pkt_ready !== exp_rdy ||
            (dest == 4 ? !(bypass_pkt_valid === 1'b1 && out_pkt_valid === 4'b0)
                       : !(out_pkt_valid === (4'b0001 << dest) && bypass_pkt_valid === 1'b0))) begin
          errors++;
          $display("FAIL pkt_route: got ready=%b valid=%b byp=%b required ready=%b dest=%0d",
                   in_pkt_ready, out_pkt_valid, bypass_pkt_valid, exp_rdy, dest);
        end
        if (in_pkt_ready) break;
        if (t >= 50) begin
          errors++;
          $display("FAIL pkt_timeout: got no beat acceptance in %0d cycles, required acceptance", t);
          break;
        end
        @(posedge clk); #1;
        if (tog && dest < 4) out_pkt_ready[dest[1:0]] = ~out_pkt_ready[dest[1:0]];
        @(negedge clk);
        t++;
      end
      @(posedge clk); #1;
      if (tog && dest < 4) out_pkt_ready[dest[1:0]] = ~out_pkt_ready[dest[1:0]];
    end
    in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_pkt_valid !== 4'b0 || out_meta_valid !== 4'b0 || bypass_pkt_valid !== 1'b0 ||
        bypass_meta_valid !== 1'b0 || in_pkt_ready !== 1'b0 || in_meta_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got pv=%b mv=%b bpv=%b bmv=%b ipr=%b imr=%b required all 0",
               out_pkt_valid, out_meta_valid, bypass_pkt_valid, bypass_meta_valid, in_pkt_ready, in_meta_ready);
    end
    checks++;
    if (stat_pkt_cnt !== 128'b0 || stat_bypass_cnt !== 32'b0) begin
      errors++;
      $display("FAIL reset_counters: got lanes=%h bypass=%h required 0", stat_pkt_cnt, stat_bypass_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_rr_rotation();
    for (int p = 0; p < 8; p++) send(lane_meta(), 1, p % 4, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stat_pkt_cnt[32*i +: 32] !== 32'(exp_cnt[i]) || exp_cnt[i] != 2) begin
        errors++;
        $display("FAIL rr_count lane %0d: got %0d required 2", i, stat_pkt_cnt[32*i +: 32]);
      end
    end
  endtask

  task automatic test_rr_skip();
    send(lane_meta(), 1, 0, -1, 1'b0);
    out_pkt_almost_full = 4'b0010;
    send(lane_meta(), 1, 2, -1, 1'b0);
    out_pkt_almost_full = 4'b0000;
    send(lane_meta(), 2, 3, -1, 1'b0);
    out_pkt_almost_full  = 4'b0101;
    out_meta_almost_full = 4'b1010;
    in_meta_data  = lane_meta();
    in_meta_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (in_meta_ready !== 1'b0 || out_meta_valid !== 4'b0) begin
        errors++;
        $display("FAIL rr_all_full: got in_meta_ready=%b out_meta_valid=%b required 0/0", in_meta_ready, out_meta_valid);
      end
      @(posedge clk); #1;
    end
    out_meta_almost_full = 4'b1000;
    send(in_meta_data, 1, 1, -1, 1'b0);
    out_pkt_almost_full  = 4'b0;
    out_meta_almost_full = 4'b0;
  endtask

  task automatic test_bypass();
    send(lane_meta() | 64'h1, 5, 4, -1, 1'b0);
    checks++;
    if (stat_bypass_cnt !== 32'(exp_cnt[4]) || exp_cnt[4] != 1) begin
      errors++;
      $display("FAIL bypass_count: got %0d required 1", stat_bypass_cnt);
    end
    checks++;
    if (stat_pkt_cnt !== {32'(exp_cnt[3]), 32'(exp_cnt[2]), 32'(exp_cnt[1]), 32'(exp_cnt[0])}) begin
      errors++;
      $display("FAIL bypass_lanes: got %h required %0d %0d %0d %0d", stat_pkt_cnt, exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] m;
    m = lane_meta();
    out_meta_ready[2] = 1'b0;
    out_pkt_ready[2]  = 1'b0;
    send(m, 4, 2, -1, 1'b1);
    @(negedge clk);
    checks++;
    if (out_meta_valid !== 4'b0100 || out_meta_data !== m) begin
      errors++;
      $display("FAIL meta_hold: got valid=%b data=%h required 0100 %h", out_meta_valid, out_meta_data, m);
    end
    @(posedge clk); #1;
    out_meta_ready[2] = 1'b1;
    @(posedge clk); #1;
    out_pkt_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (out_meta_valid !== 4'b0 || mq.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b pending meta=%0d beats=%0d required 0", out_meta_valid, mq.size(), pq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hash();
    h_in_meta_data  = 64'h0000_0003_0000_0000;
    h_in_meta_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (h_in_meta_ready !== 1'b1) begin
      errors++;
      $display("FAIL hash_accept: got %b required 1", h_in_meta_ready);
    end
    @(posedge clk); #1;
    h_in_meta_valid = 1'b0;
    h_in_pkt_valid = 1'b1; h_in_pkt_sop = 1'b1; h_in_pkt_eop = 1'b1; h_in_pkt_data = 16'hA5A5;
    @(negedge clk);
    checks++;
    if (h_out_meta_valid !== 3'b001 || h_out_pkt_valid !== 3'b001 || h_in_pkt_ready !== 1'b1 || h_out_pkt_data !== 16'hA5A5) begin
      errors++;
      $display("FAIL hash_wrap: got mv=%b pv=%b rdy=%b data=%h required 001 001 1 a5a5",
               h_out_meta_valid, h_out_pkt_valid, h_in_pkt_ready, h_out_pkt_data);
    end
    @(posedge clk); #1;
    h_in_pkt_valid = 1'b0;
    h_out_pkt_almost_full = 3'b100;
    h_in_meta_data  = 64'h0000_0002_0000_0000;
    h_in_meta_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (h_in_meta_ready !== 1'b0 || h_out_meta_valid !== 3'b0 || h_out_pkt_valid !== 3'b0) begin
        errors++;
        $display("FAIL hash_stall: got rdy=%b mv=%b pv=%b required 0 000 000", h_in_meta_ready, h_out_meta_valid, h_out_pkt_valid);
      end
      @(posedge clk); #1;
    end
    h_out_pkt_almost_full = 3'b000;
    @(negedge clk);
    checks++;
    if (h_in_meta_ready !== 1'b1) begin
      errors++;
      $display("FAIL hash_release: got %b required 1", h_in_meta_ready);
    end
    @(posedge clk); #1;
    h_in_meta_valid = 1'b0;
    h_in_pkt_valid = 1'b1; h_in_pkt_data = 16'h5A5A;
    @(negedge clk);
    checks++;
    if (h_out_meta_valid !== 3'b100 || h_out_pkt_valid !== 3'b100) begin
      errors++;
      $display("FAIL hash_lane2: got mv=%b pv=%b required 100 100", h_out_meta_valid, h_out_pkt_valid);
    end
    @(posedge clk); #1;
    h_in_pkt_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (h_stat_pkt_cnt !== {32'd1, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL hash_counts: got %h required lane0=1 lane1=0 lane2=1", h_stat_pkt_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send(lane_meta(), 4, 3, 1, 1'b0);
    @(negedge clk);
    checks++;
    if (out_pkt_valid !== 4'b0 || out_meta_valid !== 4'b0 || bypass_pkt_valid !== 1'b0 ||
        bypass_meta_valid !== 1'b0 || in_pkt_ready !== 1'b0 || in_meta_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got pv=%b mv=%b ipr=%b imr=%b required all 0",
               out_pkt_valid, out_meta_valid, in_pkt_ready, in_meta_ready);
    end
    checks++;
    if (stat_pkt_cnt !== 128'b0 || stat_bypass_cnt !== 32'b0 || h_stat_pkt_cnt !== 96'b0) begin
      errors++;
      $display("FAIL reset_mid_counters: got lanes=%h bypass=%h required 0", stat_pkt_cnt, stat_bypass_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pq.delete();
    mq.delete();
    for (int i = 0; i < 5; i++) exp_cnt[i] = 0;
    send(lane_meta(), 2, 0, -1, 1'b0);
    checks++;
    if (stat_pkt_cnt !== 128'd1) begin
      errors++;
      $display("FAIL reset_mid_restart: got %h required lane0=1 only", stat_pkt_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_pkt_data = '0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0; in_pkt_empty = '0; in_pkt_valid = 1'b0;
    in_meta_data = '0; in_meta_valid = 1'b0;
    out_pkt_ready = 4'hF; out_pkt_almost_full = 4'h0;
    out_meta_ready = 4'hF; out_meta_almost_full = 4'h0;
    bypass_pkt_ready = 1'b1; bypass_pkt_almost_full = 1'b0;
    bypass_meta_ready = 1'b1; bypass_meta_almost_full = 1'b0;
    h_in_pkt_data = '0; h_in_pkt_sop = 1'b0; h_in_pkt_eop = 1'b0; h_in_pkt_empty = '0; h_in_pkt_valid = 1'b0;
    h_in_meta_data = '0; h_in_meta_valid = 1'b0;
    h_out_pkt_ready = 3'b111; h_out_pkt_almost_full = 3'b000;
    h_out_meta_ready = 3'b111; h_out_meta_almost_full = 3'b000;
    for (int i = 0; i < 5; i++) exp_cnt[i] = 0;

    test_reset();
    test_rr_rotation();
    test_rr_skip();
    test_bypass();
    test_backpressure();
    test_hash();
    test_reset_mid();

    repeat (3) @(posedge clk);
    checks++;
    if (pq.size() != 0 || mq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d beats and %0d metas never seen, required 0", pq.size(), mq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
